// File: rtl/io_deq_policy.sv
// Dequeue-side policy for the in-order issue queue: tracks the oldest live entry and
// hands it to the functional unit through a one-entry registered valid/ready stage.
module io_deq_policy #(
    parameter int QUEUE_SIZE = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [QUEUE_SIZE-1:0] valid_dec,
    input  logic [QUEUE_SIZE-1:0] ready_dec,
    input  logic [QUEUE_SIZE-1:0] enq_ptr_oh,
    output logic [QUEUE_SIZE-1:0] deq_ptr_oh,
    output logic                  deq_fire,
    output logic [QUEUE_SIZE-1:0] deq_clear_oh,
    output logic                  issue_valid,
    output logic [QUEUE_SIZE-1:0] issue_oh,
    input  logic                  issue_ready
);

    localparam int DW = 2 * QUEUE_SIZE;

    // First set bit of vec, scanning upward from one-hot start and wrapping to bit 0.
    // The vector is doubled so the wrapped part is just the upper copy; zero if vec is zero.
    function automatic logic [QUEUE_SIZE-1:0] circ_first(
        input logic [QUEUE_SIZE-1:0] vec,
        input logic [QUEUE_SIZE-1:0] start
    );
        logic [DW-1:0] dbl;
        logic [DW-1:0] below;
        logic [DW-1:0] masked;
        logic [DW-1:0] lowest;
        dbl    = {vec, vec};
        below  = {{QUEUE_SIZE{1'b0}}, start} - {{(DW-1){1'b0}}, 1'b1};
        masked = dbl & ~below;
        lowest = masked & (~masked + {{(DW-1){1'b0}}, 1'b1});
        return lowest[QUEUE_SIZE-1:0] | lowest[DW-1:QUEUE_SIZE];
    endfunction

    logic [QUEUE_SIZE-1:0] r_deq_ptr;
    logic                  r_issue_valid;
    logic [QUEUE_SIZE-1:0] r_issue_oh;
    logic                  r_flush_q;

    logic                  w_head_ok;
    logic                  w_stage_free;
    logic                  w_fire;
    logic [QUEUE_SIZE-1:0] w_rem;
    logic [QUEUE_SIZE-1:0] w_ptr_rot;
    logic [QUEUE_SIZE-1:0] w_survivor;
    logic [QUEUE_SIZE-1:0] w_next_live;
    logic [QUEUE_SIZE-1:0] w_deq_ptr_next;

    assign w_head_ok    = |(valid_dec & ready_dec & r_deq_ptr);
    assign w_stage_free = ~r_issue_valid | issue_ready;
    // Flush and the cycle after it are blocked: valid_dec is still settling after the drop.
    assign w_fire       = w_head_ok & w_stage_free & ~flush & ~r_flush_q;

    assign w_rem       = valid_dec & ~r_deq_ptr;
    assign w_ptr_rot   = {r_deq_ptr[QUEUE_SIZE-2:0], r_deq_ptr[QUEUE_SIZE-1]};
    assign w_survivor  = circ_first(valid_dec, enq_ptr_oh);
    assign w_next_live = circ_first(w_rem, w_ptr_rot);

    always_comb begin
        w_deq_ptr_next = r_deq_ptr;
        if (r_flush_q) begin
            w_deq_ptr_next = (|valid_dec) ? w_survivor : enq_ptr_oh;
        end else if (w_fire) begin
            w_deq_ptr_next = (|w_rem) ? w_next_live : enq_ptr_oh;
        end else if (~|valid_dec) begin
            w_deq_ptr_next = enq_ptr_oh;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_deq_ptr <= {{(QUEUE_SIZE-1){1'b0}}, 1'b1};
            r_flush_q <= 1'b0;
        end else begin
            r_deq_ptr <= w_deq_ptr_next;
            r_flush_q <= flush;
        end
    end

    // Output stage: a flush drops whatever is held; fire reloads even while the old entry leaves.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_issue_valid <= 1'b0;
            r_issue_oh    <= '0;
        end else if (flush) begin
            r_issue_valid <= 1'b0;
            r_issue_oh    <= '0;
        end else if (w_fire) begin
            r_issue_valid <= 1'b1;
            r_issue_oh    <= r_deq_ptr;
        end else if (r_issue_valid & issue_ready) begin
            r_issue_valid <= 1'b0;
            r_issue_oh    <= '0;
        end
    end

    assign deq_ptr_oh   = r_deq_ptr;
    assign deq_fire     = w_fire;
    assign deq_clear_oh = w_fire ? r_deq_ptr : '0;
    assign issue_valid  = r_issue_valid;
    assign issue_oh     = r_issue_oh;

endmodule
